// File: rtl/exe_stage_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : exe_stage_pipe                                                  |
// | Brief    : RISC-V execute stage: forwarding, ALU decode, ALU, branch       |
// |            target adder, EX/MEM register with valid/ready handshake.       |
// |            Define EXE_MUL_EN to build in the iterative shift-add MUL.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module exe_stage_pipe #(
    parameter int DATA_W  = 8,
    parameter int PC_SIZE = 10,
    parameter int IMM_W   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    input  logic [PC_SIZE-1:0] PC_in,
    input  logic [DATA_W-1:0]  data1,
    input  logic [DATA_W-1:0]  data2,
    input  logic [IMM_W-1:0]   immediate,
    input  logic [9:0]         funct,
    input  logic [1:0]         alu_op,
    input  logic               alu_src,
    input  logic [1:0]         fwd_a_sel,
    input  logic [1:0]         fwd_b_sel,
    input  logic [DATA_W-1:0]  fwd_mem,
    input  logic [DATA_W-1:0]  fwd_wb,
    input  logic               branch_in,
    input  logic               mem_read_in,
    input  logic               mem_to_reg_in,
    input  logic               mem_write_in,
    input  logic               reg_write_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_SIZE-1:0] PC_jump,
    output logic [DATA_W-1:0]  ALU_result,
    output logic               zero,
    output logic [DATA_W-1:0]  write_data,
    output logic               branch_out,
    output logic               mem_read_out,
    output logic               mem_to_reg_out,
    output logic               mem_write_out,
    output logic               reg_write_out
);

    // Shift amount is operand B mod DATA_W; DATA_W is expected to be a power of two.
    localparam int SH_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_MUL
    } alu_fn_t;

    alu_fn_t              w_fn;
    logic [DATA_W-1:0]    w_op_a;
    logic [DATA_W-1:0]    w_op_b_fwd;
    logic [DATA_W-1:0]    w_op_b;
    logic [DATA_W-1:0]    w_imm_d;
    logic [PC_SIZE-1:0]   w_imm_pc;
    logic [DATA_W-1:0]    w_alu_res;
    logic [PC_SIZE-1:0]   w_pc_jump;
    logic [4:0]           w_ctl_in;
    logic                 w_can_load;
    logic                 w_accept;
    logic                 w_load;
    logic [DATA_W-1:0]    w_res_d;
    logic [PC_SIZE-1:0]   w_pc_d;
    logic [DATA_W-1:0]    w_wdata_d;
    logic [4:0]           w_ctl_d;

    logic                 r_out_valid;
    logic [PC_SIZE-1:0]   r_pc_jump;
    logic [DATA_W-1:0]    r_alu_res;
    logic                 r_zero;
    logic [DATA_W-1:0]    r_wdata;
    logic [4:0]           r_ctl;

    assign w_imm_d   = DATA_W'($signed(immediate));
    assign w_imm_pc  = PC_SIZE'($signed(immediate));
    assign w_pc_jump = PC_in + w_imm_pc;
    assign w_ctl_in  = {branch_in, mem_read_in, mem_to_reg_in, mem_write_in, reg_write_in};

    always_comb begin
        w_op_a = data1;
        case (fwd_a_sel)
            2'b01:   w_op_a = fwd_mem;
            2'b10:   w_op_a = fwd_wb;
            default: w_op_a = data1;
        endcase
    end

    always_comb begin
        w_op_b_fwd = data2;
        case (fwd_b_sel)
            2'b01:   w_op_b_fwd = fwd_mem;
            2'b10:   w_op_b_fwd = fwd_wb;
            default: w_op_b_fwd = data2;
        endcase
    end

    assign w_op_b = alu_src ? w_imm_d : w_op_b_fwd;

    always_comb begin
        w_fn = OP_ADD;
        case (alu_op)
            2'b01: w_fn = OP_SUB;
            2'b10: begin
                case (funct)
                    10'h100: w_fn = OP_SUB;
                    10'h007: w_fn = OP_AND;
                    10'h006: w_fn = OP_OR;
                    10'h004: w_fn = OP_XOR;
                    10'h001: w_fn = OP_SLL;
                    10'h005: w_fn = OP_SRL;
`ifdef EXE_MUL_EN
                    10'h008: w_fn = OP_MUL;
`endif
                    default: w_fn = OP_ADD;
                endcase
            end
            2'b11: begin
                case (funct[2:0])
                    3'b111:  w_fn = OP_AND;
                    3'b110:  w_fn = OP_OR;
                    3'b100:  w_fn = OP_XOR;
                    default: w_fn = OP_ADD;
                endcase
            end
            default: w_fn = OP_ADD;
        endcase
    end

    always_comb begin
        w_alu_res = w_op_a + w_op_b;
        case (w_fn)
            OP_SUB:  w_alu_res = w_op_a - w_op_b;
            OP_AND:  w_alu_res = w_op_a & w_op_b;
            OP_OR:   w_alu_res = w_op_a | w_op_b;
            OP_XOR:  w_alu_res = w_op_a ^ w_op_b;
            OP_SLL:  w_alu_res = w_op_a << w_op_b[SH_W-1:0];
            OP_SRL:  w_alu_res = w_op_a >> w_op_b[SH_W-1:0];
            default: w_alu_res = w_op_a + w_op_b;
        endcase
    end

    assign w_can_load = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;

`ifdef EXE_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DATA_W-1:0]    r_mcand;
    logic [DATA_W-1:0]    r_mplier;
    logic [DATA_W-1:0]    r_prod;
    logic [SH_W-1:0]      r_cnt;
    logic [PC_SIZE-1:0]   r_p_pc;
    logic [DATA_W-1:0]    r_p_wdata;
    logic [4:0]           r_p_ctl;
    logic [DATA_W-1:0]    w_prod_step;
    logic [DATA_W-1:0]    w_mul_res;
    logic                 w_last;
    logic                 w_mul_start;
    logic                 w_load_single;
    logic                 w_load_mul;

    assign in_ready    = (r_state == S_IDLE) && w_can_load;
    assign w_last      = (r_cnt == SH_W'(DATA_W - 1));
    assign w_prod_step = r_prod + (r_mplier[0] ? r_mcand : '0);
    // Final iteration result goes straight to the output register; HOLD reuses r_prod.
    assign w_mul_res   = (r_state == S_HOLD) ? r_prod : w_prod_step;

    always_comb begin
        w_state_nxt   = r_state;
        w_mul_start   = 1'b0;
        w_load_single = 1'b0;
        w_load_mul    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_fn == OP_MUL) begin
                        w_mul_start = 1'b1;
                        w_state_nxt = S_BUSY;
                    end else begin
                        w_load_single = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    if (w_can_load) begin
                        w_load_mul  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_can_load) begin
                    w_load_mul  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt   = S_IDLE;
            w_mul_start   = 1'b0;
            w_load_single = 1'b0;
            w_load_mul    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
            r_p_pc    <= '0;
            r_p_wdata <= '0;
            r_p_ctl   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_mul_start) begin
                r_mcand   <= w_op_a;
                r_mplier  <= w_op_b;
                r_prod    <= '0;
                r_cnt     <= '0;
                r_p_pc    <= w_pc_jump;
                r_p_wdata <= w_op_b_fwd;
                r_p_ctl   <= w_ctl_in;
            end else if (r_state == S_BUSY) begin
                r_prod   <= w_prod_step;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

    assign w_load    = w_load_single || w_load_mul;
    assign w_res_d   = w_load_mul ? w_mul_res : w_alu_res;
    assign w_pc_d    = w_load_mul ? r_p_pc    : w_pc_jump;
    assign w_wdata_d = w_load_mul ? r_p_wdata : w_op_b_fwd;
    assign w_ctl_d   = w_load_mul ? r_p_ctl   : w_ctl_in;
`else
    assign in_ready  = w_can_load;
    assign w_load    = w_accept && !flush;
    assign w_res_d   = w_alu_res;
    assign w_pc_d    = w_pc_jump;
    assign w_wdata_d = w_op_b_fwd;
    assign w_ctl_d   = w_ctl_in;
`endif

    // Flush only kills out_valid; datapath fields keep their stale contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_pc_jump   <= '0;
            r_alu_res   <= '0;
            r_zero      <= 1'b0;
            r_wdata     <= '0;
            r_ctl       <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_pc_jump   <= w_pc_d;
            r_alu_res   <= w_res_d;
            r_zero      <= (w_res_d == '0);
            r_wdata     <= w_wdata_d;
            r_ctl       <= w_ctl_d;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid      = r_out_valid;
    assign PC_jump        = r_pc_jump;
    assign ALU_result     = r_alu_res;
    assign zero           = r_zero;
    assign write_data     = r_wdata;
    assign branch_out     = r_ctl[4];
    assign mem_read_out   = r_ctl[3];
    assign mem_to_reg_out = r_ctl[2];
    assign mem_write_out  = r_ctl[1];
    assign reg_write_out  = r_ctl[0];

endmodule
`default_nettype wire

// File: doc/exe_stage_pipe.md
Name: exe_stage_pipe

Overview:
- Registered, parametrised execute stage for the RISC-V pipeline.
- Contains operand forwarding muxes, ALU-op decode, a single-cycle ALU, a branch-target adder, and an optional iterative multiplier.
- Owns the EX/MEM pipeline register and uses a valid/ready handshake on both sides, so downstream stalls and multi-cycle ops back-pressure decode.

Parameters:
- DATA_W, 8, datapath width of operands and result.
- PC_SIZE, 10, program-counter width.
- IMM_W, 12, immediate width; sign-extended or truncated to DATA_W and PC_SIZE.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  decode presents an op.
- in_ready  out  1  stage accepts the op this cycle.
- flush  in  1  kill the op in flight and clear the EX/MEM register.
- PC_in  in  PC_SIZE  PC of the op.
- data1, data2  in  DATA_W  register-file operands.
- immediate  in  IMM_W  signed immediate.
- funct  in  10  {funct7, funct3}.
- alu_op  in  2  00 add, 01 sub, 10 R-type, 11 I-type.
- alu_src  in  1  1 selects the immediate as operand B.
- fwd_a_sel, fwd_b_sel  in  2  00 regfile, 01 fwd_mem, 10 fwd_wb, 11 regfile.
- fwd_mem, fwd_wb  in  DATA_W  forwarded values.
- branch_in, mem_read_in, mem_to_reg_in, mem_write_in, reg_write_in  in  1  control bits.
- out_valid  out  1  EX/MEM register holds a valid op.
- out_ready  in  1  MEM stage consumes the op.
- PC_jump  out  PC_SIZE  PC_in + sext(immediate), mod 2^PC_SIZE.
- ALU_result  out  DATA_W  ALU result.
- zero  out  1  ALU_result == 0.
- write_data  out  DATA_W  forwarded operand B before the alu_src mux (store data).
- branch_out, mem_read_out, mem_to_reg_out, mem_write_out, reg_write_out  out  1  registered control bits.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, in_ready = 1 in the cycle after reset is deasserted.
- Operand A = forwarding mux on data1.
- Operand B (pre-mux) = forwarding mux on data2; this value drives write_data.
- ALU operand B = alu_src ? sext(immediate)[DATA_W-1:0] : forwarded data2.
- Decode:
  - alu_op 00 → ADD.
  - alu_op 01 → SUB.
  - alu_op 10 by funct: 0x000 ADD, 0x100 SUB, 0x007 AND, 0x006 OR, 0x004 XOR, 0x001 SLL, 0x005 SRL, 0x008 MUL; any other code → ADD.
  - alu_op 11 by funct3 only: 000 ADD, 111 AND, 110 OR, 100 XOR.
- Shift amount is operand B modulo DATA_W.
- All arithmetic wraps mod 2^DATA_W; no overflow flag.
- FSM states: IDLE, BUSY, HOLD.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- IDLE, single-cycle op accepted (in_valid && in_ready): result and control bits load the EX/MEM register at the next edge. Latency is 1 cycle and throughput is 1 op/cycle.
- IDLE, MUL accepted: latch operands, move to BUSY, and hold out_valid low for that op.
- BUSY:
  - Run DATA_W shift-add iterations, one per cycle.
  - After the final iteration: if (!out_valid || out_ready), load the register and go to IDLE; otherwise go to HOLD.
  - MUL result is the low DATA_W bits of the product.
  - Minimum MUL latency is DATA_W + 1 cycles from accept to out_valid.
- HOLD: load the register when (!out_valid || out_ready), then go to IDLE.
- Output register:
  - Holds its value while out_valid && !out_ready.
  - out_valid clears on out_ready when no new op loads in the same cycle.
- Simultaneous consume and load (out_ready with a new op accepted): the new op replaces the old one and out_valid stays 1.
- Flush has priority over every other event: out_valid ← 0, FSM → IDLE, any accept in the same cycle is dropped, and datapath outputs keep their stale values.
- Reset mid-MUL aborts the op exactly like flush and also zeroes all outputs.
- Control outputs are only meaningful while out_valid = 1; the downstream stage gates on out_valid.

Optional Feature:
- Macro EXE_MUL_EN.
- Defined: the iterative multiplier, BUSY and HOLD states are compiled in, and funct 0x008 under alu_op 10 performs MUL as described above.
- Undefined: the multiplier and the BUSY/HOLD states are removed. Funct 0x008 decodes as ADD with single-cycle latency, and in_ready = !out_valid || out_ready.

Test Plan:
- Reset then R-type ADD: data1 = 0x05, data2 = 0x03, funct 0x000, alu_op 10 → next cycle out_valid = 1, ALU_result = 0x08, zero = 0.
- Branch compare: alu_op 01, data1 = data2 = 0x2A, PC_in = 0x3FE, immediate = 0x004 → ALU_result = 0x00, zero = 1, PC_jump = 0x002 (wrap).
- Forwarding and immediate: fwd_a_sel = 01 with fwd_mem = 0x10, alu_src = 1, immediate = 0xFFF → ALU_result = 0x0F, write_data = data2.
- Back-pressure: hold out_ready = 0 with two ops presented → in_ready = 0 after the first loads, the first op's outputs stay stable, and the second op loads the cycle after out_ready = 1.
- MUL (EXE_MUL_EN defined): 0x0D × 0x0B → out_valid rises exactly 9 cycles after accept with ALU_result = 0x8F, and in_ready = 0 throughout. Flush at cycle 4 → no output, in_ready = 1 the next cycle.
- MUL with EXE_MUL_EN undefined: same stimulus → 1-cycle latency, ALU_result = 0x18.
